// File: rtl/uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
interface uart_loader_if;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_loader.sv
// UART (8N1) boot loader: receives A5, 16-bit LE word count, LE data words and writes them to instruction memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEM_WORDS    = 2056
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ser_rx,
    uart_loader_if.master mem,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF   = CNT_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);
    localparam logic [15:0]      MAX_LEN = 16'(MEM_WORDS);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LD_SYNC, LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_CSUM, LD_DONE, LD_ERR} ld_state_t;
    localparam ld_state_t LD_FINISH = LD_CSUM;
`else
    typedef enum logic [2:0] {LD_SYNC, LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_t;
    localparam ld_state_t LD_FINISH = LD_DONE;
`endif

    logic             r_sync1, r_sync2, r_rx_prev;
    logic             w_rx;
    rx_state_t        r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_byte_valid, r_frame_err;
    logic             w_bit_sample, w_byte_ok, w_frame_bad;

    ld_state_t        r_ld_state, w_ld_next;
    logic [15:0]      r_len;
    logic [15:0]      w_len;
    logic [15:0]      r_word_cnt;
    logic [1:0]       r_byte_idx;
    logic [31:0]      r_word;
    logic             r_mem_we;
    logic [11:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       r_xor;
`endif

    // The raw line is asynchronous; only r_sync2 onward is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= ser_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx = r_sync2;

    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next    = r_rx_state;
        w_bit_sample = 1'b0;
        w_byte_ok    = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !w_rx) w_rx_next = RX_START;
            RX_START: if (r_clk_cnt == HALF) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (r_clk_cnt == FULL) begin
                    w_bit_sample = 1'b1;
                    if (r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == FULL) begin
                    w_rx_next   = RX_IDLE;
                    w_byte_ok   = w_rx;
                    w_frame_bad = !w_rx;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // The bit timer restarts on every state change so each sample is one bit period after the last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_ok;
            r_frame_err  <= w_frame_bad;
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || r_clk_cnt == FULL)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 1'b1;
            if (r_rx_state == RX_IDLE)
                r_bit_cnt <= '0;
            else if (w_bit_sample)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_bit_sample)
                r_shift <= {w_rx, r_shift[7:1]};
        end
    end

    assign w_len = {r_shift, r_len[7:0]};

    always_ff @(posedge clk) begin
        if (reset) r_ld_state <= LD_SYNC;
        else       r_ld_state <= w_ld_next;
    end

    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            LD_SYNC:   if (r_byte_valid && r_shift == SYNC_BYTE) w_ld_next = LD_LEN_LO;
            LD_LEN_LO: if (r_byte_valid) w_ld_next = LD_LEN_HI;
            LD_LEN_HI: begin
                if (r_byte_valid) begin
                    if (w_len > MAX_LEN)    w_ld_next = LD_ERR;
                    else if (w_len == 16'd0) w_ld_next = LD_FINISH;
                    else                     w_ld_next = LD_DATA;
                end
            end
            // Leave DATA only while the final strobe is on the bus, so mem_we stays inside DATA.
            LD_DATA:   if (r_mem_we && r_word_cnt == r_len) w_ld_next = LD_FINISH;
`ifdef LOADER_CHECKSUM_EN
            LD_CSUM:   if (r_byte_valid) w_ld_next = (r_shift == r_xor) ? LD_DONE : LD_ERR;
`endif
            LD_DONE:   w_ld_next = LD_DONE;
            LD_ERR:    w_ld_next = LD_ERR;
            default:   w_ld_next = LD_ERR;
        endcase
        if (r_frame_err && r_ld_state != LD_DONE && r_ld_state != LD_ERR)
            w_ld_next = LD_ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (r_ld_state == LD_LEN_LO && r_byte_valid)
                r_len[7:0] <= r_shift;
            if (r_ld_state == LD_LEN_HI && r_byte_valid) begin
                r_len      <= w_len;
                r_word_cnt <= '0;
                r_byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_xor      <= '0;
`endif
            end
            if (r_ld_state == LD_DATA && r_byte_valid) begin
                r_word     <= {r_shift, r_word[31:8]};
                r_byte_idx <= r_byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                r_xor      <= r_xor ^ r_shift;
`endif
                if (r_byte_idx == 2'd3 && r_word_cnt < MAX_LEN) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_word_cnt[11:0];
                    r_mem_wdata <= {r_shift, r_word[31:8]};
                    r_word_cnt  <= r_word_cnt + 16'd1;
                end
            end
        end
    end

    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign done          = (r_ld_state == LD_DONE);
    assign error         = (r_ld_state == LD_ERR);
    assign cpu_reset     = (r_ld_state != LD_DONE);

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter: MEM_WORDS, default 2056, instruction-memory depth in 32-bit words.
REQ-003 Port: clk  input  1  sole clock; all logic on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: ser_rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 Port: mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-007 Port: mem_addr  output  12  word index of the write; index 0 = byte address 0x8000_0000.
REQ-008 Port: mem_wdata  output  32  word to write; valid while mem_we=1.
REQ-009 Port: cpu_reset  output  1  held high until the image loads successfully.
REQ-010 Port: done  output  1  sticky, image loaded.
REQ-011 Port: error  output  1  sticky, load failed.

Function
REQ-012 ser_rx shall pass through a 2-flop synchronizer before any use.
REQ-013 RX states: IDLE, START, DATA, STOP.
- IDLE -> START on synchronized falling edge.
REQ-014 START sampling:
- Samples the line at CLKS_PER_BIT/2.
- Low -> DATA; high -> IDLE as a glitch, with no byte and no error.
REQ-015 DATA shall sample 8 bits, each CLKS_PER_BIT after the previous sample, shifting LSB first.
REQ-016 STOP sampling, CLKS_PER_BIT after bit 7:
- High -> byte_valid for exactly one cycle, then IDLE.
- Low -> framing error, loader to ERR, then IDLE.
REQ-017 Loader states: SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
REQ-018 SYNC:
- Discards every byte except 0xA5.
- 0xA5 -> LEN_LO.
REQ-019 Word count N:
- LEN_LO and LEN_HI capture N, 16-bit little-endian.
- At LEN_HI, N > MEM_WORDS -> ERR.
- N = 0 -> CSUM when LOADER_CHECKSUM_EN is defined, else DONE.
REQ-020 DATA assembly:
- Bytes are assembled little-endian: first byte into [7:0], fourth into [31:24].
- On the cycle after the fourth byte's byte_valid: mem_we=1, mem_addr = word counter, mem_wdata = assembled word.
- The word counter then increments.
REQ-021 After word N-1 is written, DATA -> CSUM or DONE per REQ-019.
REQ-022 mem_we shall never assert outside DATA, and never with mem_addr >= MEM_WORDS.
REQ-023 DONE: done=1, cpu_reset=0; all further ser_rx traffic is ignored until reset.
REQ-024 ERR: error=1, cpu_reset=1, no further writes until reset.
REQ-025 done and error shall never both be 1.

Reset
REQ-026 While reset=1, registers take these values:
- Outputs: mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0.
- RX=IDLE, loader=SYNC, counters and shift registers 0, synchronizer flops 1.
REQ-027 Reset asserted mid-byte or mid-image shall abort the partial byte and load, with no spurious mem_we.
- Memory words already written are left unchanged.

Configuration
REQ-028 With LOADER_CHECKSUM_EN defined:
- CSUM consumes one byte, compared against the XOR of all 4N data bytes (0x00 when N=0).
- Equal -> DONE; unequal -> ERR.
REQ-029 With LOADER_CHECKSUM_EN undefined, the CSUM state and XOR accumulator are absent and DATA goes straight to DONE.

Verification
REQ-030 Load with CLKS_PER_BIT=16, checksum off:
- Send A5 02 00 13 00 00 00 6F 00 00 00.
- Expect writes [0]=0x00000013 and [1]=0x0000006F, then done=1, cpu_reset=0.
REQ-031 Leading junk:
- Send 00 FF then the REQ-030 stream.
- Expect junk ignored and identical writes.
REQ-032 Framing error:
- Stop bit driven low on the 2nd data byte.
- Expect error=1, cpu_reset=1, no write.
REQ-033 Oversized image:
- Send A5 09 08 (N = 0x0809 > 2056).
- Expect error=1 and zero mem_we.
REQ-034 Checksum, LOADER_CHECKSUM_EN defined:
- REQ-030 stream plus 7C -> done=1.
- Repeat with 7D instead of 7C -> error=1, cpu_reset=1.
REQ-035 Glitch and reset:
- A 3-cycle low pulse on ser_rx -> no byte.
- Reset asserted during the 3rd data byte -> outputs per REQ-026.
- A fresh REQ-030 stream then succeeds.
